// File: rtl/trace_pkg.sv
// Shared definitions for the instruction trace buffer: record kinds and record layout.
package trace_pkg;

    typedef enum logic [2:0] {
        KIND_NOP  = 3'd0,
        KIND_REG  = 3'd1,
        KIND_LD   = 3'd2,
        KIND_ST   = 3'd3,
        KIND_HALT = 3'd4
    } kind_e;

    localparam int KIND_W = 3;

    // Canonical field widths of a trace record; trace_buffer resizes the same layout to its parameters.
    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;
    localparam int DEF_RW = 4;
    localparam int DEF_CW = 32;

    typedef struct packed {
        kind_e              kind;
        logic [DEF_CW-1:0]  inum;
        logic [DEF_AW-1:0]  pc;
        logic [DEF_RW-1:0]  rid;
        logic [DEF_DW-1:0]  value;
        logic [DEF_AW-1:0]  addr;
    } trace_rec_t;

    // Packed width of a record for the given field widths.
    function automatic int rec_width(input int aw, input int dw, input int rw, input int cw);
        return KIND_W + cw + aw + rw + dw + aw;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO holding trace records: head entry is visible combinationally while not empty.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle; flush wins over both.
    always_comb begin
        do_pop   = pop & ~empty & ~flush;
        do_push  = push & (~full | do_pop) & ~flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(do_push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(do_pop);
        level_d  = flush ? '0 : level_q + LW'(do_push) - LW'(do_pop);
    end

    // Pointer and occupancy state; reset discards contents without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Record storage, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/trace_buffer.sv
// Retired-instruction trace capture: classifies events, numbers them and queues records for a consumer.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int RW    = 4,
    parameter int CW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     ev_valid,
    input  logic [AW-1:0]            ev_pc,
    input  logic                     ev_regwrite,
    input  logic [RW-1:0]            ev_reg,
    input  logic [DW-1:0]            ev_wdata,
    input  logic                     ev_memread,
    input  logic                     ev_memwrite,
    input  logic [AW-1:0]            ev_memaddr,
    input  logic [DW-1:0]            ev_memdata,
    input  logic                     ev_halt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_kind,
    output logic [CW-1:0]            out_inum,
    output logic [AW-1:0]            out_pc,
    output logic [RW-1:0]            out_reg,
    output logic [DW-1:0]            out_value,
    output logic [AW-1:0]            out_addr,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CW-1:0]            cycle_count,
    output logic [CW-1:0]            inst_count,
    output logic                     overflow,
    output logic                     halted,
    output logic                     drained
);
    localparam int LW   = $clog2(DEPTH) + 1;
    localparam int RECW = rec_width(AW, DW, RW, CW);

    // Same field order as trace_rec_t, sized by this instance's parameters.
    typedef struct packed {
        kind_e          kind;
        logic [CW-1:0]  inum;
        logic [AW-1:0]  pc;
        logic [RW-1:0]  rid;
        logic [DW-1:0]  value;
        logic [AW-1:0]  addr;
    } rec_t;

    rec_t              push_rec, head_rec;
    logic [RECW-1:0]   head_bits;
    kind_e             ev_kind;
    logic              accept, pop, fifo_full, fifo_empty;
    logic [LW-1:0]     fifo_level;
    logic [CW-1:0]     cycle_count_q, cycle_count_d;
    logic [CW-1:0]     inst_count_q, inst_count_d;
    logic              overflow_q, overflow_d;
    logic              halted_q, halted_d;

    assign accept = ev_valid & en & ~halted_q & ~clr;
    assign pop    = ~fifo_empty & out_ready;

    // Classify the event and build its record; fields that do not apply to the kind are zero.
    always_comb begin
        ev_kind = KIND_NOP;
        if (ev_regwrite && ev_memread) ev_kind = KIND_LD;
        else if (ev_regwrite)          ev_kind = KIND_REG;
        else if (ev_halt)              ev_kind = KIND_HALT;
        else if (ev_memwrite)          ev_kind = KIND_ST;

        push_rec       = '0;
        push_rec.kind  = ev_kind;
        push_rec.inum  = inst_count_q;
        push_rec.pc    = ev_pc;
        if (ev_kind == KIND_REG || ev_kind == KIND_LD) begin
            push_rec.rid   = ev_reg;
            push_rec.value = ev_wdata;
        end else if (ev_kind == KIND_ST) begin
            push_rec.value = ev_memdata;
        end
        if (ev_kind == KIND_LD || ev_kind == KIND_ST) begin
            push_rec.addr = ev_memaddr;
        end
    end

    // Next-state of counters and flags; clr clears everything and suppresses counting.
    always_comb begin
        cycle_count_d = cycle_count_q;
        inst_count_d  = inst_count_q;
        overflow_d    = overflow_q;
        halted_d      = halted_q;
        if (clr) begin
            cycle_count_d = '0;
            inst_count_d  = '0;
            overflow_d    = 1'b0;
            halted_d      = 1'b0;
        end else begin
            if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CW'(1);
            if (accept) begin
                inst_count_d = inst_count_q + CW'(1);
                if (fifo_full && !pop)    overflow_d = 1'b1;
                if (ev_kind == KIND_HALT) halted_d   = 1'b1;
            end
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_q <= '0;
            inst_count_q  <= '0;
            overflow_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            cycle_count_q <= cycle_count_d;
            inst_count_q  <= inst_count_d;
            overflow_q    <= overflow_d;
            halted_q      <= halted_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RECW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clr),
        .push  (accept),
        .wdata (push_rec),
        .pop   (pop),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign head_rec = rec_t'(head_bits);

    // Present the head record, forcing all fields to zero while nothing is queued.
    always_comb begin
        out_valid = ~fifo_empty;
        out_kind  = fifo_empty ? 3'd0 : head_rec.kind;
        out_inum  = fifo_empty ? '0   : head_rec.inum;
        out_pc    = fifo_empty ? '0   : head_rec.pc;
        out_reg   = fifo_empty ? '0   : head_rec.rid;
        out_value = fifo_empty ? '0   : head_rec.value;
        out_addr  = fifo_empty ? '0   : head_rec.addr;
    end

    assign level       = fifo_level;
    assign cycle_count = cycle_count_q;
    assign inst_count  = inst_count_q;
    assign overflow    = overflow_q;
    assign halted      = halted_q;
    assign drained     = halted_q & fifo_empty;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed and randomized checks of trace_buffer against a queue-based reference model.
module tb_trace_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int RW    = 4;
    localparam int CW    = 8;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst_n, clr, en, ev_valid, ev_regwrite, ev_memread, ev_memwrite, ev_halt, out_ready;
    logic [AW-1:0] ev_pc, ev_memaddr;
    logic [RW-1:0] ev_reg;
    logic [DW-1:0] ev_wdata, ev_memdata;
    logic          out_valid, overflow, halted, drained;
    logic [2:0]    out_kind;
    logic [CW-1:0] out_inum, cycle_count, inst_count;
    logic [AW-1:0] out_pc, out_addr;
    logic [RW-1:0] out_reg;
    logic [DW-1:0] out_value;
    logic [LW-1:0] level;

    trace_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .ev_valid(ev_valid), .ev_pc(ev_pc),
        .ev_regwrite(ev_regwrite), .ev_reg(ev_reg), .ev_wdata(ev_wdata), .ev_memread(ev_memread),
        .ev_memwrite(ev_memwrite), .ev_memaddr(ev_memaddr), .ev_memdata(ev_memdata), .ev_halt(ev_halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_inum(out_inum),
        .out_pc(out_pc), .out_reg(out_reg), .out_value(out_value), .out_addr(out_addr),
        .level(level), .cycle_count(cycle_count), .inst_count(inst_count), .overflow(overflow),
        .halted(halted), .drained(drained)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            kind;
        logic [CW-1:0] inum;
        logic [AW-1:0] pc;
        logic [RW-1:0] rid;
        logic [DW-1:0] value;
        logic [AW-1:0] addr;
    } rec_s;

    rec_s q[$];
    int   m_cyc, m_inst;
    bit   m_ovf, m_halt;
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cyc = 0; m_inst = 0; m_ovf = 0; m_halt = 0;
    endtask

    // One clock edge of the reference behaviour, from the inputs currently driven.
    task automatic model_update();
        rec_s r;
        bit   popped;
        if (!rst_n) begin
            model_reset();
        end else if (clr) begin
            model_reset();
        end else begin
            popped = (q.size() > 0) && out_ready;
            if (m_cyc < (2**CW) - 1) m_cyc++;
            if (popped) void'(q.pop_front());
            if (ev_valid && en && !m_halt) begin
                r.pc = ev_pc; r.rid = '0; r.value = '0; r.addr = '0;
                r.inum = m_inst[CW-1:0];
                if (ev_regwrite && ev_memread) begin
                    r.kind = 2; r.rid = ev_reg; r.value = ev_wdata; r.addr = ev_memaddr;
                end else if (ev_regwrite) begin
                    r.kind = 1; r.rid = ev_reg; r.value = ev_wdata;
                end else if (ev_halt) begin
                    r.kind = 4;
                end else if (ev_memwrite) begin
                    r.kind = 3; r.value = ev_memdata; r.addr = ev_memaddr;
                end else begin
                    r.kind = 0;
                end
                if (q.size() < DEPTH) q.push_back(r);
                else m_ovf = 1;
                m_inst = (m_inst + 1) % (2**CW);
                if (r.kind == 4) m_halt = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        rec_s h;
        h = '{kind: 0, inum: '0, pc: '0, rid: '0, value: '0, addr: '0};
        if (q.size() > 0) h = q[0];
        chk({tag, ".out_valid"},   64'(out_valid),   64'(q.size() > 0));
        chk({tag, ".out_kind"},    64'(out_kind),    64'(h.kind));
        chk({tag, ".out_inum"},    64'(out_inum),    64'(h.inum));
        chk({tag, ".out_pc"},      64'(out_pc),      64'(h.pc));
        chk({tag, ".out_reg"},     64'(out_reg),     64'(h.rid));
        chk({tag, ".out_value"},   64'(out_value),   64'(h.value));
        chk({tag, ".out_addr"},    64'(out_addr),    64'(h.addr));
        chk({tag, ".level"},       64'(level),       64'(q.size()));
        chk({tag, ".cycle_count"}, 64'(cycle_count), 64'(m_cyc));
        chk({tag, ".inst_count"},  64'(inst_count),  64'(m_inst));
        chk({tag, ".overflow"},    64'(overflow),    64'(m_ovf));
        chk({tag, ".halted"},      64'(halted),      64'(m_halt));
        chk({tag, ".drained"},     64'(drained),     64'(m_halt && q.size() == 0));
    endtask

    task automatic tick(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic ev(input logic [AW-1:0] pc, input logic rw, input logic [RW-1:0] r,
                      input logic [DW-1:0] wd, input logic mr, input logic mw,
                      input logic [AW-1:0] ma, input logic [DW-1:0] md, input logic h);
        ev_valid = 1'b1; ev_pc = pc; ev_regwrite = rw; ev_reg = r; ev_wdata = wd;
        ev_memread = mr; ev_memwrite = mw; ev_memaddr = ma; ev_memdata = md; ev_halt = h;
    endtask

    task automatic idle();
        ev_valid = 1'b0; ev_pc = '0; ev_regwrite = 1'b0; ev_reg = '0; ev_wdata = '0;
        ev_memread = 1'b0; ev_memwrite = 1'b0; ev_memaddr = '0; ev_memdata = '0; ev_halt = 1'b0;
    endtask

    task automatic nop_ev();
        ev(AW'($urandom), 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_clr();
        clr = 1'b1; idle(); tick("clr"); clr = 1'b0;
    endtask

    task automatic rand_ev(input bit allow_halt);
        ev_valid    = ($urandom % 10) < 8;
        ev_pc       = AW'($urandom);
        ev_regwrite = 1'($urandom);
        ev_reg      = RW'($urandom);
        ev_wdata    = DW'($urandom);
        ev_memread  = 1'($urandom);
        ev_memwrite = 1'($urandom);
        ev_memaddr  = AW'($urandom);
        ev_memdata  = DW'($urandom);
        ev_halt     = allow_halt ? (($urandom % 12) == 0) : 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; en = 1'b1; out_ready = 1'b0;
        idle();
        model_reset();

        // Reset state
        @(posedge clk); #1;
        check_all("reset");
        tick("reset_hold");
        rst_n = 1'b1;

        // REG then ST with consumer ready
        out_ready = 1'b1;
        ev(16'h0000, 1'b1, 4'd3, 16'h00AA, 1'b0, 1'b0, '0, '0, 1'b0);
        tick("r19a");
        chk("r19.kind0",  64'(out_kind),  64'd1);
        chk("r19.inum0",  64'(out_inum),  64'd0);
        chk("r19.reg0",   64'(out_reg),   64'd3);
        chk("r19.value0", 64'(out_value), 64'h00AA);
        ev(16'h0004, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0);
        tick("r19b");
        chk("r19.kind1",  64'(out_kind),  64'd3);
        chk("r19.inum1",  64'(out_inum),  64'd1);
        chk("r19.addr1",  64'(out_addr),  64'h0010);
        chk("r19.value1", 64'(out_value), 64'h1234);
        idle();
        tick("r19c");

        // Overflow with a stalled consumer, then drain
        do_clr();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nop_ev();
            tick("r20fill");
        end
        chk("r20.level",    64'(level),      64'd4);
        chk("r20.overflow", 64'(overflow),   64'd1);
        chk("r20.inst",     64'(inst_count), 64'd6);
        idle();
        for (int i = 0; i < 4; i++) begin
            chk("r20.drain_inum", 64'(out_inum), 64'(i));
            out_ready = 1'b1;
            tick("r20drain");
        end
        chk("r20.empty", 64'(out_valid), 64'd0);

        // Full FIFO with simultaneous pop
        do_clr();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nop_ev();
            tick("r21fill");
        end
        out_ready = 1'b1;
        nop_ev();
        tick("r21push");
        chk("r21.level",    64'(level),    64'd4);
        chk("r21.overflow", 64'(overflow), 64'd0);
        idle();
        for (int i = 0; i < 4; i++) tick("r21drain");

        // Kind priority, halt and drain
        do_clr();
        out_ready = 1'b0;
        ev(16'h0100, 1'b1, 4'd5, 16'h5555, 1'b1, 1'b1, 16'h0200, 16'h6666, 1'b1);
        tick("r22ld");
        chk("r22.kind_ld", 64'(out_kind), 64'd2);
        ev(16'h0104, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        tick("r22halt");
        chk("r22.halted", 64'(halted), 64'd1);
        for (int i = 0; i < 3; i++) begin
            nop_ev();
            tick("r22ignored");
        end
        chk("r22.inst",    64'(inst_count), 64'd2);
        chk("r22.drained0", 64'(drained),   64'd0);
        idle();
        out_ready = 1'b1;
        tick("r22pop1");
        tick("r22pop2");
        chk("r22.drained1", 64'(drained), 64'd1);

        // clr beats a concurrent event
        do_clr();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nop_ev();
            tick("r23fill");
        end
        chk("r23.level3", 64'(level), 64'd3);
        clr = 1'b1;
        nop_ev();
        tick("r23clr");
        clr = 1'b0;
        chk("r23.level", 64'(level),       64'd0);
        chk("r23.inst",  64'(inst_count),  64'd0);
        chk("r23.cyc",   64'(cycle_count), 64'd0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 2; i++) begin
            nop_ev();
            tick("r24fill");
        end
        chk("r24.level2", 64'(level), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("r24async");
        idle();
        tick("r24hold");
        rst_n = 1'b1;
        nop_ev();
        tick("r24resume");
        chk("r24.inum", 64'(out_inum), 64'd0);

        // Random traffic without halt: cycle counter saturation and inum wrap
        do_clr();
        en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rand_ev(1'b0);
            ev_valid  = ($urandom % 10) < 9;
            out_ready = ($urandom % 3) != 0;
            tick("randA");
        end
        chk("randA.cyc_sat", 64'(cycle_count), 64'd255);

        // Fully random traffic with halts, enables and clears
        for (int i = 0; i < 400; i++) begin
            rand_ev(1'b1);
            en        = ($urandom % 8) != 0;
            clr       = ($urandom % 40) == 0;
            out_ready = ($urandom % 2) == 0;
            tick("randB");
        end
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameters: DEPTH, default 16, FIFO entries (power of 2, >=2); AW, default 16, PC/memory address width; DW, default 16, data width; RW, default 4, register-id width; CW, default 32, counter width.
REQ-002 SHALL have ports (one clock; reset asynchronous, active-low):
  clk  in  1  clock
  rst_n  in  1  asynchronous active-low reset
  clr  in  1  synchronous flush of FIFO, counters and flags
  en  in  1  capture enable
  ev_valid  in  1  one retired instruction this cycle
  ev_pc  in  AW  PC of retired instruction
  ev_regwrite  in  1  register written
  ev_reg  in  RW  destination register
  ev_wdata  in  DW  register write data
  ev_memread  in  1  load
  ev_memwrite  in  1  store
  ev_memaddr  in  AW  memory address
  ev_memdata  in  DW  store data
  ev_halt  in  1  halt retired
  out_valid  out  1  record available
  out_ready  in  1  consumer accepts record
  out_kind  out  3  0 NOP, 1 REG, 2 LD, 3 ST, 4 HALT
  out_inum  out  CW  instruction number
  out_pc  out  AW  record PC
  out_reg  out  RW  register id (REG/LD, else 0)
  out_value  out  DW  wdata (REG/LD) or memdata (ST), else 0
  out_addr  out  AW  memaddr (LD/ST), else 0
  level  out  $clog2(DEPTH)+1  entries held
  cycle_count  out  CW  cycles since reset/clr
  inst_count  out  CW  events accepted
  overflow  out  1  sticky: record dropped
  halted  out  1  HALT accepted
  drained  out  1  halted and FIFO empty

Function
REQ-003 Event accepted when ev_valid & en & !halted & !clr; otherwise ignored, counters unchanged.
REQ-004 Kind priority: ev_regwrite&ev_memread -> LD; ev_regwrite -> REG; ev_halt -> HALT; ev_memwrite -> ST; else NOP.
REQ-005 Accepted event gets out_inum = inst_count value before increment; inst_count increments by 1 per accepted event, wrapping modulo 2^CW.
REQ-006 Push latency 1: record accepted at edge N is visible with out_valid=1 after edge N if FIFO was empty.
REQ-007 Pop occurs when out_valid & out_ready; out_* outputs show the head entry, are held stable while out_valid & !out_ready.
REQ-008 Full (level==DEPTH) with no pop: accepted event dropped, overflow set, inst_count still increments (gap in inum visible).
REQ-009 Full with simultaneous pop: push accepted, level unchanged, no overflow.
REQ-010 Empty: out_valid=0; out_* outputs 0.
REQ-011 Pointers wrap modulo DEPTH; level = pushes - pops, range 0..DEPTH.
REQ-012 HALT accepted sets halted on same edge; halted blocks further accepts; drained = halted & level==0.
REQ-013 cycle_count increments every cycle while not in reset and not clr; saturates at 2^CW-1.
REQ-014 clr has priority over push, pop and counting: next cycle level, counters, overflow, halted all 0.

Reset
REQ-015 While rst_n=0: out_valid=0, all out_* 0, level=0, cycle_count=0, inst_count=0, overflow=0, halted=0, drained=0; pointers 0.
REQ-016 Reset asserted mid-operation SHALL discard FIFO contents immediately (asynchronous); capture resumes on the first edge after release.

Structure
REQ-017 Shared package trace_pkg SHALL hold the kind encodings (NOP/REG/LD/ST/HALT) and the trace record type.
REQ-018 FIFO storage/pointers SHALL be a sub-module trace_fifo (parameters DEPTH, record width; push/pop/full/empty/level); classification and counters stay in trace_buffer.

Verification
REQ-019 Reset, then events REG r3=0x00AA pc 0x0000, ST addr 0x0010 data 0x1234, out_ready=1 -> records kind1/inum0/reg3/value 0x00AA, then kind3/inum1/addr 0x0010/value 0x1234.
REQ-020 DEPTH=4, out_ready=0, 6 NOP events -> level=4, overflow=1, inst_count=6; drain gives inum 0..3.
REQ-021 Full FIFO, push with out_ready=1 same cycle -> level stays 4, overflow stays 0, new inum appended.
REQ-022 ev_regwrite&ev_memread&ev_halt together -> kind LD; then HALT event -> halted=1, later events ignored, drained=1 after last pop.
REQ-023 clr asserted with ev_valid=1 and level=3 -> next cycle level=0, inst_count=0, cycle_count=0, no record pushed.
REQ-024 rst_n dropped mid-burst with level=2 -> out_valid=0 immediately, all counters 0; first event after release gets inum 0.
